// File: rtl/imem_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared fetch-stage types, widths and state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_FETCH = 2'd1;
    localparam logic [1:0] C_ST_FAULT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_FETCH = C_ST_FETCH,
        ST_FAULT = C_ST_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Address is unusable if not word aligned or beyond a 2**aw word memory.
    function automatic logic addr_bad(input logic [PC_W-1:0] a, input int aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl_if
// Description : imem, decode handshake and redirect signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if
    import mips_pkg::*;
#(
    parameter int AW = 6
);
    logic                enable;
    logic [AW-1:0]       imem_addr;
    logic [INSTR_W-1:0]  imem_rd;
    logic                instr_valid;
    logic [INSTR_W-1:0]  instr;
    logic [PC_W-1:0]     instr_pc;
    logic                instr_ready;
    logic                redirect_valid;
    logic [PC_W-1:0]     redirect_pc;
    logic                fault;
    logic [PC_W-1:0]     fault_pc;

    modport master (
        input  enable, imem_rd, instr_ready, redirect_valid, redirect_pc,
        output imem_addr, instr_valid, instr, instr_pc, fault, fault_pc
    );

    modport slave (
        output enable, imem_rd, instr_ready, redirect_valid, redirect_pc,
        input  imem_addr, instr_valid, instr, instr_pc, fault, fault_pc
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf2
// Description : Two-entry {pc, instr} FIFO with push, pop, flush and count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf2
    import mips_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_push,
    input  wire fetch_entry_t i_push_data,
    input  wire logic         i_pop,
    input  wire logic         i_flush,
    output fetch_entry_t      o_head,
    output logic [1:0]        o_count
);

    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;
    logic [1:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_pop, w_push})
                2'b10: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent1 <= i_push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : PC owner and fetch sequencer feeding decode from imem.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int          AW       = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  wire logic          clk,
    input  wire logic          reset,
    imem_fetch_ctrl_if.master  bus
);

    fetch_state_t      r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_fault;
    logic [PC_W-1:0]   r_fault_pc;

    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;
    logic [1:0]        w_count;
    logic              w_valid;
    logic              w_pop;
    logic              w_in_fault;
    logic              w_redirect;
    logic              w_space;
    logic              w_try_push;
    logic              w_pc_bad;
    logic              w_rpc_bad;
    logic              w_push;

    assign w_valid    = (w_count != 2'd0);
    assign w_pop      = w_valid && bus.instr_ready;
    assign w_in_fault = (r_state == ST_FAULT);
    assign w_redirect = bus.redirect_valid && !w_in_fault;
    assign w_space    = (w_count != 2'd2) || w_pop;
    assign w_pc_bad   = addr_bad(r_pc, AW);
    assign w_rpc_bad  = addr_bad(bus.redirect_pc, AW);

    // Pushing on enable rather than on the FETCH state gives the one-cycle
    // start-up latency out of IDLE.
    assign w_try_push = !w_in_fault && bus.enable && !w_redirect && w_space;
    assign w_push     = w_try_push && !w_pc_bad;

    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = bus.imem_rd;

    fetch_buf2 u_buf (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_redirect),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            case (r_state)
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    if (w_redirect) begin
                        r_pc <= bus.redirect_pc;
                        if (w_rpc_bad) begin
                            r_state    <= ST_FAULT;
                            r_fault    <= 1'b1;
                            r_fault_pc <= bus.redirect_pc;
                        end else begin
                            r_state <= bus.enable ? ST_FETCH : ST_IDLE;
                        end
                    end else if (w_try_push && w_pc_bad) begin
                        r_state    <= ST_FAULT;
                        r_fault    <= 1'b1;
                        r_fault_pc <= r_pc;
                    end else begin
                        if (w_push) begin
                            r_pc <= r_pc + 32'd4;
                        end
                        r_state <= bus.enable ? ST_FETCH : ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.imem_addr   = r_pc[AW+1:2];
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? w_head.instr : NOP;
    assign bus.instr_pc    = w_valid ? w_head.pc : '0;
    assign bus.fault       = r_fault;
    assign bus.fault_pc    = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Directed and random checks of imem_fetch_ctrl against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk;
    logic reset;
    logic [31:0] mem [64];

    int n_checks;
    int n_errors;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    bit          m_fault;

    imem_fetch_ctrl_if #(.AW(6)) bus ();

    imem_fetch_ctrl #(.AW(6), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_rd = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h100);
    endfunction

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst, input bit en, input bit rdy,
                        input bit rv, input logic [31:0] rpc);
        bit   pop;
        ent_t e;
        reset              = rst;
        bus.enable         = en;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_fpc   = 32'h0;
        end else begin
            pop = (q.size() != 0) && rdy;
            if (!m_fault && rv) begin
                q.delete();
                m_pc = rpc;
                if (bad(rpc)) begin
                    m_fault = 1'b1;
                    m_fpc   = rpc;
                end
            end else begin
                if (pop) void'(q.pop_front());
                if (!m_fault && en && q.size() < 2) begin
                    if (bad(m_pc)) begin
                        m_fault = 1'b1;
                        m_fpc   = m_pc;
                    end else begin
                        e.pc  = m_pc;
                        e.ins = mem[m_pc[7:2]];
                        q.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
        #1;
        chk("valid", {31'd0, bus.instr_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("instr", bus.instr, q[0].ins);
            chk("instr_pc", bus.instr_pc, q[0].pc);
        end
        chk("fault", {31'd0, bus.fault}, {31'd0, m_fault});
        chk("fault_pc", bus.fault_pc, m_fpc);
        chk("imem_addr", {26'd0, bus.imem_addr}, {26'd0, m_pc[7:2]});
    endtask

    initial begin
        bit          rst_r, en_r, rdy_r, rv_r;
        logic [31:0] rpc_r;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'h2002_0005;
        mem[1]  = 32'h2003_000c;
        mem[2]  = 32'h2067_fff7;
        mem[17] = 32'hac02_0054;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);

        // Straight-line stream
        step(0, 1, 1, 0, 0);
        chk("seq0", bus.instr, 32'h2002_0005);
        step(0, 1, 1, 0, 0);
        chk("seq1", bus.instr, 32'h2003_000c);
        step(0, 1, 1, 0, 0);
        chk("seq2", bus.instr, 32'h2067_fff7);

        // Stall with full buffer, then drain
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        chk("stall_addr", {26'd0, bus.imem_addr}, 32'd2);
        chk("stall_head", bus.instr, 32'h2002_0005);
        step(0, 1, 1, 0, 0);
        chk("drain1", bus.instr, 32'h2003_000c);
        step(0, 1, 1, 0, 0);
        chk("drain2", bus.instr, 32'h2067_fff7);

        // Redirect while full
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 32'h44);
        chk("redir_flush", {31'd0, bus.instr_valid}, 32'd0);
        step(0, 1, 1, 0, 0);
        chk("redir_instr", bus.instr, 32'hac02_0054);
        chk("redir_pc", bus.instr_pc, 32'h44);

        // Misaligned redirect faults
        step(0, 1, 1, 1, 32'h46);
        chk("mis_fault", {31'd0, bus.fault}, 32'd1);
        chk("mis_fault_pc", bus.fault_pc, 32'h46);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 32'h8);
        step(1, 1, 1, 0, 0);
        chk("mis_clear", {31'd0, bus.fault}, 32'd0);
        step(0, 1, 1, 0, 0);
        chk("mis_restart", bus.instr, 32'h2002_0005);

        // Run off the end of imem
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 66; i++) step(0, 1, 1, 0, 0);
        chk("end_fault", {31'd0, bus.fault}, 32'd1);
        chk("end_fault_pc", bus.fault_pc, 32'h100);

        // Reset mid-stream with a full buffer
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        step(0, 1, 1, 0, 0);
        chk("mid_rst_resume", bus.instr, 32'h2002_0005);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_r = (m_fault && $urandom_range(0, 9) == 0) || ($urandom_range(0, 199) == 0);
            en_r  = ($urandom_range(0, 9) != 0);
            rdy_r = ($urandom_range(0, 2) != 0);
            rv_r  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0:       rpc_r = {$urandom} | 32'h1;
                1:       rpc_r = 32'h100 + {22'd0, $urandom_range(0, 255), 2'b00};
                2:       rpc_r = 32'hfc;
                default: rpc_r = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            step(rst_r, en_r, rdy_r, rv_r, rpc_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
